// File: rtl/sample_lane_distributor_if.sv
// Bundle for the sample distributor's streaming signals: one input word stream
// plus NUM_LANES output lane streams.
//
// Handshake: every stream uses valid/ready. A word moves on a rising edge
// where both valid and ready are high. A source keeps valid and data steady
// until the word is taken. Ready may depend on valid in the same cycle.
interface sample_lane_distributor_if #(
  parameter int NUM_LANES   = 4,
  parameter int SAMPLE_BITS = 48
);
  logic [SAMPLE_BITS-1:0]           in_data;
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_LANES*SAMPLE_BITS-1:0] lane_data;
  logic [NUM_LANES-1:0]             lane_valid;
  logic [NUM_LANES-1:0]             lane_ready;

  // Source/consumer side (drives input words, accepts lane words)
  modport master (
    output in_data, in_valid, lane_ready,
    input  in_ready, lane_data, lane_valid
  );

  // Distributor side
  modport slave (
    input  in_data, in_valid, lane_ready,
    output in_ready, lane_data, lane_valid
  );
endinterface

// File: rtl/sample_lane_distributor.sv
// Round-robin distributor that spreads input sample words across the active
// lanes. Each lane has a first-word-fall-through FIFO. The active lane count
// is re-latched only at frame boundaries, so a frame is never split between
// two lane counts.
module sample_lane_distributor #(
  parameter int NUM_LANES   = 4,
  parameter int SAMPLE_BITS = 48,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           sample_clk,
  input  logic                           reset_n,
  sample_lane_distributor_if.slave       bus,
  input  logic [$clog2(NUM_LANES+1)-1:0] active_lanes,
  input  logic                           restart,
  output logic [$clog2(NUM_LANES)-1:0]   lane_index,
  output logic [15:0]                    frame_count,
  output logic [NUM_LANES-1:0]           overflow_lane
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int AW = $clog2(NUM_LANES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [SAMPLE_BITS-1:0] r_mem   [NUM_LANES][FIFO_DEPTH];
  logic [PW-1:0]          r_wptr  [NUM_LANES];
  logic [PW-1:0]          r_rptr  [NUM_LANES];
  logic [CW-1:0]          r_count [NUM_LANES];
  logic [LW-1:0]          r_lane_index;
  logic [AW-1:0]          r_n_act;
  logic [15:0]            r_frame_count;
  logic [NUM_LANES-1:0]   r_overflow;

  logic [AW-1:0]          w_n_req;
  logic [NUM_LANES-1:0]   w_full;
  logic [NUM_LANES-1:0]   w_empty;
  logic [NUM_LANES-1:0]   w_pop;
  logic [NUM_LANES-1:0]   w_push;
  logic [LW-1:0]          w_last_idx;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_wrap;

  // Clamp the requested lane count into 1..NUM_LANES
  always_comb begin
    w_n_req = active_lanes;
    if (active_lanes == '0) begin
      w_n_req = AW'(1);
    end else if (active_lanes > AW'(NUM_LANES)) begin
      w_n_req = AW'(NUM_LANES);
    end
  end

  // Per-lane FIFO status and push/pop strobes
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    w_pop   = '0;
    w_push  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_full[k]  = (r_count[k] == CW'(FIFO_DEPTH));
      w_empty[k] = (r_count[k] == '0);
      w_pop[k]   = !w_empty[k] && bus.lane_ready[k];
      w_push[k]  = w_accept && (r_lane_index == LW'(k));
    end
  end

  // A full target lane blocks input even if it pops this cycle (no bypass)
  assign w_in_ready   = !w_full[r_lane_index] && !restart && reset_n;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_last_idx   = LW'(r_n_act - AW'(1));
  assign w_wrap       = w_accept && (r_lane_index == w_last_idx);

  assign bus.in_ready   = w_in_ready;
  assign bus.lane_valid = ~w_empty;
  assign lane_index     = r_lane_index;
  assign frame_count    = r_frame_count;
  assign overflow_lane  = r_overflow;

  // Present each lane's head word; empty lanes read as zero
  always_comb begin
    bus.lane_data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!w_empty[k]) begin
        bus.lane_data[k*SAMPLE_BITS +: SAMPLE_BITS] = r_mem[k][r_rptr[k]];
      end
    end
  end

  // Round-robin lane pointer, frame counter, lane-count latch, overflow flags
  always_ff @(posedge sample_clk) begin
    if (!reset_n || restart) begin
      r_lane_index  <= '0;
      r_frame_count <= '0;
      r_overflow    <= '0;
      r_n_act       <= w_n_req;
    end else begin
      if (w_accept) begin
        if (w_wrap) begin
          r_lane_index  <= '0;
          r_frame_count <= r_frame_count + 16'd1;
          r_n_act       <= w_n_req;
        end else begin
          r_lane_index <= r_lane_index + LW'(1);
        end
      end
      if (bus.in_valid && !w_in_ready) begin
        r_overflow[r_lane_index] <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together leave occupancy alone
  always_ff @(posedge sample_clk) begin
    if (!reset_n || restart) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_count[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + PW'(1);
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + PW'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + CW'(1);
          2'b01:   r_count[k] <= r_count[k] - CW'(1);
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  // Word storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge sample_clk) begin
    if (w_accept) begin
      r_mem[r_lane_index][r_wptr[r_lane_index]] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_sample_lane_distributor.sv
// Bench for sample_lane_distributor: a queue-based lane model plus directed
// scenarios with literal expectations and a randomized soak.
module tb_sample_lane_distributor;
  localparam int NL    = 4;
  localparam int SB    = 48;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        sample_clk = 1'b0;
  logic        reset_n;
  logic        restart;
  logic [2:0]  active_lanes;
  logic [1:0]  lane_index;
  logic [15:0] frame_count;
  logic [3:0]  overflow_lane;

  always #5 sample_clk = ~sample_clk;

  sample_lane_distributor_if #(.NUM_LANES(NL), .SAMPLE_BITS(SB)) bus ();

  sample_lane_distributor #(.NUM_LANES(NL), .SAMPLE_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .sample_clk    (sample_clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .active_lanes  (active_lanes),
    .restart       (restart),
    .lane_index    (lane_index),
    .frame_count   (frame_count),
    .overflow_lane (overflow_lane)
  );

  // ---------------- reference model ----------------
  logic [SB-1:0] exp_q [NL][$];
  int            m_idx;
  int            m_nact;
  int            m_frame;
  logic [NL-1:0] m_ovf;
  bit            m_accepted;
  int            n_checks;
  int            n_fail;
  bit            check_en;

  function automatic int clamp_lanes(int a);
    if (a == 0) return 1;
    if (a > NL) return NL;
    return a;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven
  task automatic model_step();
    bit rdy;
    m_accepted = 1'b0;
    if (!reset_n || restart) begin
      for (int k = 0; k < NL; k++) exp_q[k].delete();
      m_idx   = 0;
      m_frame = 0;
      m_ovf   = '0;
      m_nact  = clamp_lanes(int'(active_lanes));
      return;
    end
    rdy = exp_q[m_idx].size() < DEPTH;
    for (int k = 0; k < NL; k++)
      if (exp_q[k].size() > 0 && bus.lane_ready[k]) void'(exp_q[k].pop_front());
    if (bus.in_valid && rdy) begin
      exp_q[m_idx].push_back(bus.in_data);
      m_accepted = 1'b1;
      if (m_idx == m_nact - 1) begin
        m_idx   = 0;
        m_frame = (m_frame + 1) % 65536;
        m_nact  = clamp_lanes(int'(active_lanes));
      end else begin
        m_idx++;
      end
    end else if (bus.in_valid) begin
      m_ovf[m_idx] = 1'b1;
    end
  endtask

  function automatic logic exp_in_ready();
    return reset_n && !restart && (exp_q[m_idx].size() < DEPTH);
  endfunction

  function automatic logic [NL-1:0] exp_lane_valid();
    logic [NL-1:0] v = '0;
    for (int k = 0; k < NL; k++) v[k] = exp_q[k].size() > 0;
    return v;
  endfunction

  function automatic logic [NL*SB-1:0] exp_lane_data();
    logic [NL*SB-1:0] d = '0;
    for (int k = 0; k < NL; k++)
      if (exp_q[k].size() > 0) d[k*SB +: SB] = exp_q[k][0];
    return d;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [NL*SB-1:0] act, logic [NL*SB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the active edge
  always @(negedge sample_clk) begin
    if (check_en) begin
      check("in_ready",      bus.in_ready,   exp_in_ready());
      check("lane_valid",    bus.lane_valid, exp_lane_valid());
      check("lane_data",     bus.lane_data,  exp_lane_data());
      check("lane_index",    lane_index,     m_idx);
      check("frame_count",   frame_count,    m_frame);
      check("overflow_lane", overflow_lane,  m_ovf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sample_clk);
    model_step();
    #1;
  endtask

  task automatic push_word(logic [SB-1:0] w);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    do begin
      tick();
      n++;
    end while (!m_accepted && n < 50);
    bus.in_valid = 1'b0;
    check("push_accept_bound", m_accepted, 1'b1);
  endtask

  // Hold in_valid for a number of cycles, counting up the data on each accept
  task automatic feed(int cycles, inout int w);
    bus.in_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      bus.in_data = SB'(w);
      tick();
      if (m_accepted) w++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.lane_ready = '0;
    active_lanes   = 3'd4;
    restart        = 1'b0;
    reset_n        = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    check_en = 1'b0;

    // Reset state
    tick();
    tick();
    check_en = 1'b1;
    @(negedge sample_clk);
    check("lit_reset_in_ready",   bus.in_ready,   1'b0);
    check("lit_reset_lane_valid", bus.lane_valid, 4'h0);
    check("lit_reset_frame",      frame_count,    16'd0);
    tick();
    reset_n = 1'b1;
    @(negedge sample_clk);
    check("lit_ready_after_reset", bus.in_ready, 1'b1);

    // Eight words over four lanes, consumers held off to inspect the heads
    for (int i = 0; i < 8; i++) push_word(SB'(i));
    @(negedge sample_clk);
    check("lit_4lane_lane0_head", bus.lane_data[0*SB +: SB], 48'd0);
    check("lit_4lane_lane3_head", bus.lane_data[3*SB +: SB], 48'd3);
    check("lit_4lane_frame",      frame_count, 16'd2);
    check("lit_4lane_index",      lane_index,  2'd0);
    bus.lane_ready = 4'b0001;
    tick();
    bus.lane_ready = 4'b0000;
    @(negedge sample_clk);
    check("lit_4lane_lane0_second", bus.lane_data[0*SB +: SB], 48'd4);

    // Lane 1 stalled: fills after four words, input stalls targeting lane 1
    pulse_restart();
    bus.lane_ready = 4'b1101;
    w = 0;
    feed(30, w);
    bus.in_valid = 1'b1;
    bus.in_data  = SB'(w);
    @(negedge sample_clk);
    check("lit_stall_in_ready", bus.in_ready,  1'b0);
    check("lit_stall_index",    lane_index,    2'd1);
    check("lit_stall_overflow", overflow_lane, 4'b0010);
    check("lit_stall_accepted", w,             17);
    tick();
    bus.lane_ready = 4'hF;
    feed(30, w);
    for (int i = 0; i < 8; i++) tick();

    // Lane count change mid-frame takes effect at the next wrap
    pulse_restart();
    bus.lane_ready = 4'h0;
    push_word(48'd0);
    push_word(48'd1);
    active_lanes = 3'd2;
    for (int i = 2; i < 8; i++) push_word(SB'(i));
    @(negedge sample_clk);
    check("lit_chg_lane2_head", bus.lane_data[2*SB +: SB], 48'd2);
    check("lit_chg_lane3_head", bus.lane_data[3*SB +: SB], 48'd3);
    check("lit_chg_frame",      frame_count, 16'd3);
    bus.lane_ready = 4'hF;
    for (int i = 0; i < 6; i++) tick();
    bus.lane_ready = 4'h0;

    // Zero lanes clamps to one; seven clamps to four
    active_lanes = 3'd0;
    pulse_restart();
    for (int i = 0; i < 3; i++) push_word(SB'(100 + i));
    @(negedge sample_clk);
    check("lit_one_lane_frame", frame_count,    16'd3);
    check("lit_one_lane_valid", bus.lane_valid, 4'b0001);
    active_lanes = 3'd7;
    pulse_restart();
    for (int i = 0; i < 5; i++) push_word(SB'(200 + i));
    @(negedge sample_clk);
    check("lit_clamp4_frame", frame_count, 16'd1);
    check("lit_clamp4_index", lane_index,  2'd1);
    check("lit_clamp4_lane0_head", bus.lane_data[0*SB +: SB], 48'd200);

    // Restart with words buffered and an overflow flag raised
    w = 300;
    feed(20, w);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    @(negedge sample_clk);
    check("lit_restart_valid",    bus.lane_valid, 4'h0);
    check("lit_restart_index",    lane_index,     2'd0);
    check("lit_restart_frame",    frame_count,    16'd0);
    check("lit_restart_overflow", overflow_lane,  4'h0);

    // Randomized soak with occasional restarts, resets and lane-count changes
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_data    = {$urandom, $urandom};
      bus.lane_ready = 4'($urandom_range(0, 15));
      restart        = ($urandom_range(0, 63) == 0);
      reset_n        = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 31) == 0) active_lanes = 3'($urandom_range(0, 7));
      tick();
    end
    restart = 1'b0;
    reset_n = 1'b1;
    bus.in_valid = 1'b0;

    // One-cycle reset mid-stream discards everything
    active_lanes   = 3'd3;
    pulse_restart();
    bus.lane_ready = 4'h0;
    w = 0;
    feed(6, w);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge sample_clk);
    check("lit_midreset_valid", bus.lane_valid, 4'h0);
    check("lit_midreset_frame", frame_count,    16'd0);
    check("lit_midreset_index", lane_index,     2'd0);

    // Frame counter wraps modulo 2^16 with one lane and continuous flow
    active_lanes   = 3'd1;
    pulse_restart();
    bus.lane_ready = 4'hF;
    w = 0;
    feed(65535, w);
    @(negedge sample_clk);
    check("lit_wrap_ffff", frame_count, 16'hFFFF);
    w = 0;
    feed(1, w);
    @(negedge sample_clk);
    check("lit_wrap_zero", frame_count, 16'h0000);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sample_lane_distributor.md
SAMPLE_LANE_DISTRIBUTOR -- requirements
Module: sample_lane_distributor

Interface
REQ-001 Parameter NUM_LANES, default 4, number of serial output lanes (2..16).
REQ-002 Parameter SAMPLE_BITS, default 48, width of one stereo sample word.
REQ-003 Parameter FIFO_DEPTH, default 4, per-lane buffer depth in words (power of 2, >=2).
REQ-004 sample_clk  input  1  clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 in_data  input  SAMPLE_BITS  sample word from testbench/source.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  word accepted when in_valid && in_ready.
REQ-009 lane_data  output  NUM_LANES*SAMPLE_BITS  lane k word in bits [k*SAMPLE_BITS +: SAMPLE_BITS].
REQ-010 lane_valid  output  NUM_LANES  lane k head word valid.
REQ-011 lane_ready  input  NUM_LANES  lane k consumer pops when lane_valid[k] && lane_ready[k].
REQ-012 active_lanes  input  $clog2(NUM_LANES+1)  requested number of lanes in use.
REQ-013 restart  input  1  synchronous flush and re-align pulse.
REQ-014 lane_index  output  $clog2(NUM_LANES)  lane the next accepted word goes to.
REQ-015 frame_count  output  16  completed round-robin frames, wraps modulo 2^16.
REQ-016 overflow_lane  output  NUM_LANES  sticky: in_valid held while target lane FIFO full.

Function
REQ-017 Internal active count n_act SHALL be latched active_lanes, clamped: 0 -> 1, >NUM_LANES -> NUM_LANES.
REQ-018 n_act SHALL update only on restart, reset, or in the cycle lane_index wraps to 0; mid-frame changes to active_lanes have no effect until then.
REQ-019 in_ready SHALL be combinational: !full[lane_index] && !restart && reset_n.
REQ-020 On accept, word SHALL be written to FIFO[lane_index]; lane_index increments, wrapping to 0 after n_act-1.
REQ-021 On each wrap to 0, frame_count SHALL increment by 1.
REQ-022 Each lane FIFO SHALL be first-word-fall-through: lane_valid[k] = !empty[k], lane_data = head word, zero latency from write-to-head beyond one cycle (word written at edge t visible after edge t).
REQ-023 Pop on lane k SHALL advance its read pointer; simultaneous push and pop on same lane SHALL keep occupancy unchanged.
REQ-024 Push to a full FIFO SHALL never occur (in_ready low); a pop in the same cycle does not raise in_ready (no bypass).
REQ-025 Lanes k >= n_act SHALL keep lane_valid[k]=0 for new data; words already buffered there remain poppable.
REQ-026 overflow_lane[lane_index] SHALL set when in_valid && !in_ready && !restart; cleared only by reset or restart.
REQ-027 restart SHALL, at the next edge: empty all FIFOs, lane_index=0, frame_count=0, overflow_lane=0, latch n_act; in_valid during restart is ignored.
REQ-028 Ordering: words SHALL leave each lane in arrival order; lane k receives input words k, k+n_act, k+2*n_act, ...
REQ-029 Occupancy counters SHALL be $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 While reset_n=0 at an edge: all FIFOs empty, lane_index=0, frame_count=0, overflow_lane=0, n_act latched per REQ-017.
REQ-031 During and after reset: lane_valid=0, lane_data=0 for empty lanes, in_ready=0 while reset_n=0, 1 on first cycle after.
REQ-032 Reset mid-transfer SHALL discard buffered words without emitting partial state.

Verification
REQ-033 Defaults, active_lanes=4, lane_ready all 1, push 8 words 0..7 -> lane0 gets 0,4; lane3 gets 3,7; frame_count=2; lane_index=0.
REQ-034 lane_ready[1]=0, push continuously -> after lane1 holds 4 words in_ready falls with lane_index=1; overflow_lane=4'b0010; release lane_ready[1] -> flow resumes, order preserved.
REQ-035 active_lanes changed 4->2 after 2 accepted words -> words 2,3 still go to lanes 2,3; thereafter alternate lanes 0,1.
REQ-036 active_lanes=0 -> all words to lane0, frame_count increments every word; active_lanes=7 with NUM_LANES=4 -> behaves as 4.
REQ-037 restart pulsed with 3 words buffered -> next cycle all lane_valid=0, lane_index=0, frame_count=0, overflow cleared.
REQ-038 reset_n=0 for 1 cycle mid-stream -> state per REQ-030; frame_count 16'hFFFF + 1 frame -> 0.
